iter_fixed_point_div: RTL and testbench

Iterative signed fixed-point divider computing out = ina / inb using a radix-2 restoring shift-subtract loop. Operands and result use parameterised integer/fraction widths. The block has a valid/ready input handshake and a one-cycle o_valid result pulse. It is the multi-cycle counterpart of the pipelined fixed-point multiplier and sits in the same arithmetic library, where an area-cheap division is acceptable at a fixed latency.

---
 rtl/iter_fixed_point_div_pkg.sv | 22 ++
 rtl/iter_fixed_point_div_if.sv | 17 +
 rtl/iter_fixed_point_div_zoom.sv | 34 +++
 rtl/iter_fixed_point_div.sv | 128 ++++++++++++
 tb/tb_iter_fixed_point_div.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/iter_fixed_point_div_pkg.sv
// Shared types and width helpers for the iterative fixed-point divider.
package fixed_point_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nq(input int wiia, input int wifa, input int wifb, input int wof);
    return wiia + wifa + wifb + wof + 1;
  endfunction

  function automatic int zoom_wii(input int wiia, input int wifb);
    return wiia + wifb + 1;
  endfunction

  function automatic int zoom_wif(input int wifa, input int wof);
    return wifa + wof + 1;
  endfunction

endpackage

// File: rtl/iter_fixed_point_div_if.sv
// Operand/result handshake bundle for iter_fixed_point_div.
interface iter_fixed_point_div_if #(
  parameter int WA = 16,
  parameter int WB = 16,
  parameter int WO = 16
);
  logic          i_valid;
  logic          i_ready;
  logic [WA-1:0] ina;
  logic [WB-1:0] inb;
  logic          o_valid;
  logic [WO-1:0] out;
  logic          overflow;

  modport master (output i_valid, ina, inb, input i_ready, o_valid, out, overflow);
  modport slave  (input i_valid, ina, inb, output i_ready, o_valid, out, overflow);
endinterface

// File: rtl/iter_fixed_point_div_zoom.sv
// Combinational format trim WII.WIF -> WOI.WOF with rounding/truncation toward zero and saturation.
// Assumes WIF > WOF and WII >= WOI.
module comb_FixedPointZoom #(
  parameter int WII   = 17,
  parameter int WIF   = 17,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter bit ROUND = 1'b1
) (
  input  logic [WII+WIF-1:0] i_x,
  output logic [WOI+WOF-1:0] o_y,
  output logic               o_ovf
);
  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
  localparam int SH = WIF - WOF;

  logic signed [WI:0] w_ext;
  logic signed [WI:0] w_shift;
  logic               w_inc;
  logic        [WI:0] w_r;
  logic               w_fit;

  assign w_ext   = {i_x[WI-1], i_x};
  assign w_shift = w_ext >>> SH;
  // Round: add the guard bit to the floored value. Truncate: step a negative inexact value back toward zero.
  assign w_inc   = ROUND ? i_x[SH-1] : (i_x[WI-1] & (|i_x[SH-1:0]));
  assign w_r     = w_shift + {{WI{1'b0}}, w_inc};
  assign w_fit   = (&w_r[WI:WO-1]) | ~(|w_r[WI:WO-1]);

  assign o_y   = w_fit ? w_r[WO-1:0]
               : (w_r[WI] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}});
  assign o_ovf = ~w_fit;
endmodule

// File: rtl/iter_fixed_point_div.sv
// Iterative signed fixed-point divider: radix-2 restoring shift-subtract, fixed NQ+2 cycle period.
module iter_fixed_point_div
  import fixed_point_div_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter bit ROUND = 1'b1
) (
  input logic                clk,
  input logic                rst,
  iter_fixed_point_div_if.slave bus
);
  localparam int WA   = WIIA + WIFA;
  localparam int WB   = WIIB + WIFB;
  localparam int WO   = WOI + WOF;
  localparam int NQ   = calc_nq(WIIA, WIFA, WIFB, WOF);
  localparam int ZWII = zoom_wii(WIIA, WIFB);
  localparam int ZWIF = zoom_wif(WIFA, WOF);
  localparam int SHN  = WIFB + WOF + 1;
  localparam int CW   = $clog2(NQ);
  localparam logic [WO-1:0] MAXP = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MINN = {1'b1, {(WO-1){1'b0}}};

  state_t          r_state;
  logic [NQ-1:0]   r_num;
  logic [WB-1:0]   r_den;
  logic [WB-1:0]   r_rem;
  logic [NQ-1:0]   r_quo;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_dz;
  logic            r_ready;
  logic            r_valid;
  logic [WO-1:0]   r_out;
  logic            r_ovf;

  // Unsigned WA-bit negation is exact for the most negative operand (2^(WA-1) fits unsigned).
  logic [WA-1:0]   w_a_mag;
  logic [WB-1:0]   w_b_mag;
  logic [NQ-1:0]   w_num;
  logic [WB:0]     w_trial;
  logic [WB-1:0]   w_diff;
  logic            w_ge;
  logic [NQ:0]     w_sq;
  logic [WO-1:0]   w_zoom;
  logic            w_zoom_ovf;

  assign w_a_mag = bus.ina[WA-1] ? (~bus.ina + WA'(1'b1)) : bus.ina;
  assign w_b_mag = bus.inb[WB-1] ? (~bus.inb + WB'(1'b1)) : bus.inb;
  assign w_num   = {w_a_mag, {SHN{1'b0}}};
  assign w_trial = {r_rem, r_num[NQ-1]};
  assign w_ge    = (w_trial >= {1'b0, r_den});
  assign w_diff  = w_trial[WB-1:0] - r_den;
  assign w_sq    = r_neg ? (~{1'b0, r_quo} + (NQ+1)'(1'b1)) : {1'b0, r_quo};

  comb_FixedPointZoom #(
    .WII(ZWII), .WIF(ZWIF), .WOI(WOI), .WOF(WOF), .ROUND(ROUND)
  ) u_zoom (
    .i_x  (w_sq),
    .o_y  (w_zoom),
    .o_ovf(w_zoom_ovf)
  );

  // Control FSM plus remainder/quotient datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_num   <= '0;
      r_den   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_num   <= w_num;
            r_den   <= w_b_mag;
            r_neg   <= bus.ina[WA-1] ^ bus.inb[WB-1];
            r_dz    <= (bus.inb == '0);
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= CW'(NQ - 1);
            r_ready <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff : w_trial[WB-1:0];
          r_num <= r_num << 1;
          r_quo <= {r_quo[NQ-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1'b1);
          end
        end
        DONE: begin
          r_out   <= r_dz ? (r_neg ? MINN : MAXP) : w_zoom;
          r_ovf   <= r_dz | w_zoom_ovf;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.i_ready  = r_ready;
  assign bus.o_valid  = r_valid;
  assign bus.out      = r_out;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_iter_fixed_point_div.sv
// Self-checking bench: ROUND=1 and ROUND=0 dividers in lockstep, table vectors plus scoreboard.
module tb_iter_fixed_point_div;
  localparam int NQ = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_fixed_point_div_if #(.WA(16), .WB(16), .WO(16)) bus_r1 ();
  iter_fixed_point_div_if #(.WA(16), .WB(16), .WO(16)) bus_r0 ();

  iter_fixed_point_div #(.ROUND(1'b1)) dut_r1 (.clk(clk), .rst(rst), .bus(bus_r1));
  iter_fixed_point_div #(.ROUND(1'b0)) dut_r0 (.clk(clk), .rst(rst), .bus(bus_r0));

  typedef struct {
    logic [15:0] a, b, e1, e0;
    logic        v1, v0;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a, b, e1, e0;
    logic        ov;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ov_count = 0;
  logic prev_v   = 1'b0;
  exp_t sbq[$];
  vec_t vt[11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void sat(input longint v, output logic [15:0] r, output logic ov);
    if (v > 32767) begin
      r = 16'h7FFF; ov = 1'b1;
    end else if (v < -32768) begin
      r = 16'h8000; ov = 1'b1;
    end else begin
      r = 16'(v); ov = 1'b0;
    end
  endfunction

  // Reference: exact integer quotient at 2^-17 scale, then round-nearest or truncate-toward-zero to 2^-8.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] e1, output logic [15:0] e0,
                                output logic v1, output logic v0);
    longint sa, sbv, ma, mb, q, s;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    if (mb == 0) begin
      e1 = (sa < 0) ? 16'h8000 : 16'h7FFF;
      e0 = e1; v1 = 1'b1; v0 = 1'b1;
    end else begin
      q = (ma <<< 17) / mb;
      s = ((sa < 0) != (sbv < 0)) ? -q : q;
      sat((s + 256) >>> 9, e1, v1);
      sat((s < 0) ? -((-s) >>> 9) : (s >>> 9), e0, v0);
    end
  endfunction

  task automatic drive(input logic vld, input logic [15:0] a, input logic [15:0] b);
    bus_r1.i_valid = vld; bus_r1.ina = a; bus_r1.inb = b;
    bus_r0.i_valid = vld; bus_r0.ina = a; bus_r0.inb = b;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e1,
                      input logic [15:0] e0, input logic v1, input logic v0, input int acc);
    exp_t e;
    e.a = a; e.b = b; e.e1 = e1; e.e0 = e0; e.v1 = v1; e.v0 = v0; e.acc = acc;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e1,
                       input logic [15:0] e0, input logic v1, input logic v0);
    int n = 0;
    @(negedge clk);
    drive(1'b1, a, b);
    while (!bus_r1.i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    else push(a, b, e1, e0, v1, v0, cyc + 1);
    @(negedge clk);
    drive(1'b0, a, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("result_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (prev_v) chk("o_valid_pulse_width", 32'(bus_r1.o_valid), 32'd0);
    if (bus_r1.o_valid || bus_r0.o_valid) begin
      ov_count <= ov_count + 1;
      chk("o_valid_r0_vs_r1", 32'(bus_r0.o_valid), 32'(bus_r1.o_valid));
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_o_valid actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("out_r1 %h/%h", e.a, e.b), 32'(bus_r1.out), 32'(e.e1));
        chk($sformatf("ovf_r1 %h/%h", e.a, e.b), 32'(bus_r1.overflow), 32'(e.v1));
        chk($sformatf("out_r0 %h/%h", e.a, e.b), 32'(bus_r0.out), 32'(e.e0));
        chk($sformatf("ovf_r0 %h/%h", e.a, e.b), 32'(bus_r0.overflow), 32'(e.v0));
        chk($sformatf("latency %h/%h", e.a, e.b), 32'(cyc - e.acc), 32'(NQ + 1));
      end
    end
    prev_v <= bus_r1.o_valid;
  end

  initial begin
    logic [15:0] a, b, e1, e0;
    logic        v1, v0;
    int          last_acc, ov_before, acc;

    //        ina       inb       ROUND=1   ROUND=0   ovf
    vt[0]  = '{16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0};
    vt[1]  = '{16'hFF00, 16'h0300, 16'hFFAB, 16'hFFAB, 1'b0};
    vt[2]  = '{16'h0200, 16'h0300, 16'h00AB, 16'h00AA, 1'b0};
    vt[3]  = '{16'h7F00, 16'h0080, 16'h7FFF, 16'h7FFF, 1'b1};
    vt[4]  = '{16'h8100, 16'h0080, 16'h8000, 16'h8000, 1'b1};
    vt[5]  = '{16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1};
    vt[6]  = '{16'hFF00, 16'h0000, 16'h8000, 16'h8000, 1'b1};
    vt[7]  = '{16'h8000, 16'h8000, 16'h0100, 16'h0100, 1'b0};
    vt[8]  = '{16'h8000, 16'h0100, 16'h8000, 16'h8000, 1'b0};
    vt[9]  = '{16'h0080, 16'h8000, 16'hFFFF, 16'hFFFF, 1'b0};
    vt[10] = '{16'h0000, 16'h0300, 16'h0000, 16'h0000, 1'b0};

    drive(1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_i_ready", 32'(bus_r1.i_ready), 32'd1);
    chk("reset_o_valid", 32'(bus_r1.o_valid), 32'd0);
    chk("reset_out", 32'(bus_r1.out), 32'd0);
    chk("reset_overflow", 32'(bus_r1.overflow), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].e1, vt[i].e0, vt[i].ov, vt[i].ov);
      wait_idle();
    end

    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = (i < 3) ? 16'($urandom_range(1, 255)) : 16'($urandom);
      model(a, b, e1, e0, v1, v0);
      issue(a, b, e1, e0, v1, v0);
      wait_idle();
    end

    // i_valid held high with operands changing every cycle.
    last_acc = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom_range(16, 4095));
      drive(1'b1, a, b);
      if (bus_r1.i_ready) begin
        acc = cyc + 1;
        model(a, b, e1, e0, v1, v0);
        push(a, b, e1, e0, v1, v0, acc);
        if (last_acc >= 0) chk("accept_spacing", 32'(acc - last_acc), 32'(NQ + 2));
        last_acc = acc;
      end
    end
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000);
    wait_idle();

    // Abort a division 10 cycles into CALC.
    @(negedge clk);
    drive(1'b1, 16'h0300, 16'h0200);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out", 32'(bus_r1.out), 32'd0);
    chk("abort_overflow", 32'(bus_r1.overflow), 32'd0);
    chk("abort_i_ready", 32'(bus_r1.i_ready), 32'd1);
    chk("abort_o_valid", 32'(bus_r1.o_valid), 32'd0);
    ov_before = ov_count;
    rst = 1'b0;
    repeat (NQ + 5) @(negedge clk);
    chk("abort_no_o_valid", 32'(ov_count - ov_before), 32'd0);
    issue(16'h0200, 16'h0300, 16'h00AB, 16'h00AA, 1'b0, 1'b0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
